// File: rtl/present80_enc_core.sv
// present80_enc_core -- iterative PRESENT-80 block cipher, encryption only.
//
// One full round per clock: addRoundKey -> S-layer -> p_layer, with the
// 80-bit key schedule advancing alongside. After ROUNDS rounds the result is
// whitened with the next round key (K32 for the standard 31 rounds) and held
// in a registered output until the consumer takes it.
//
// Handshake: valid/ready on both sides, a single block in flight.
// States: IDLE (accepting) -> RUN (rounds) -> DONE (ciphertext held).
//
// Optional feature: define PRESENT80_ABORT_EN to add an `abort` input that
// drops the block in flight (RUN or DONE) and returns to IDLE while keeping
// the previous ciphertext on out_data.

// 64-bit PRESENT bit permutation: bit i moves to position 16*i mod 63,
// except bit 63, which stays in place. Pure wiring, no logic.
module present80_p_layer (
    input  logic [63:0] din,
    output logic [63:0] dout
);

    for (genvar i = 0; i < 64; i++) begin : g_perm
        localparam int DST = (i == 63) ? 63 : (i * 16) % 63;
        assign dout[DST] = din[i];
    end

endmodule

module present80_enc_core #(
    parameter int ROUNDS = 31            // legal 1..31; 31 is standard PRESENT-80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [79:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
`ifdef PRESENT80_ABORT_EN
    ,
    input  logic        abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Round number on which the final round is computed and whitened.
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    fsm_t        fsm;
    logic [63:0] state;
    logic [79:0] key;
    logic [4:0]  round;

    logic [63:0] mixed;
    logic [63:0] sboxed;
    logic [63:0] next_state;
    logic [79:0] rotated;
    logic [79:0] next_key;
    logic        abort_hit;

`ifdef PRESENT80_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // PRESENT 4-bit S-box.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // addRoundKey: the round key is the top 64 bits of the key register.
    assign mixed = state ^ key[79:16];

    // S-layer over all sixteen nibbles of the mixed state.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        sboxed = '0;
        for (int n = 0; n < 16; n++) begin
            sboxed[4*n +: 4] = sbox(mixed[4*n +: 4]);
        end
    end

    present80_p_layer u_p_layer (
        .din  (sboxed),
        .dout (next_state)
    );

    // Key schedule: rotate left by 61, S-box the top nibble, fold in the round counter.
    assign rotated = {key[18:0], key[79:19]};

    // Assemble the next round key from the rotated register.
    always_comb begin
        next_key          = rotated;
        next_key[79:76]   = sbox(rotated[79:76]);
        next_key[19:15]   = rotated[19:15] ^ round;
    end

    // Control FSM plus all datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            fsm       <= IDLE;
            state     <= '0;
            key       <= '0;
            round     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state    <= in_data;
                        key      <= in_key;
                        round    <= 5'd1;
                        fsm      <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                RUN: begin
                    if (abort_hit) begin
                        fsm      <= IDLE;
                        round    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state <= next_state;
                        key   <= next_key;
                        if (round == LAST_ROUND) begin
                            // Final round: whiten with the freshly derived key.
                            out_data  <= next_state ^ next_key[79:16];
                            out_valid <= 1'b1;
                            fsm       <= DONE;
                        end else begin
                            round <= round + 5'd1;
                        end
                    end
                end

                DONE: begin
                    // Hold the ciphertext until taken (or dropped by abort).
                    if (abort_hit || out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        round     <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    round     <= '0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present80_enc_core.sv
// Directed testbench for present80_enc_core (ROUNDS = 31) using the
// published PRESENT-80 test vectors, backpressure, and reset mid-run.
// With PRESENT80_ABORT_EN defined it also exercises abort mid-run.
module tb_present80_enc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [79:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic        abort;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] KF = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] P0 = 64'h0;
    localparam logic [63:0] PF = 64'hFFFF_FFFF_FFFF_FFFF;

    present80_enc_core #(.ROUNDS(31)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef PRESENT80_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    // Offer one block and wait (bounded) for it to be accepted.
    task automatic start_block(input logic [63:0] pt, input logic [79:0] k, input string tag);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        check({tag, " ready"}, 80'(in_ready), 80'(1));
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = k;
        step();
        in_valid = 1'b0;
        // Scramble inputs after acceptance; the core must ignore them.
        in_data  = {$urandom, $urandom};
        in_key   = 80'({$urandom, $urandom, $urandom});
        check({tag, " busy"}, 80'(busy), 80'(1));
        check({tag, " in_ready low"}, 80'(in_ready), 80'(0));
    endtask

    // Count edges until out_valid, then check latency and ciphertext.
    task automatic finish_block(input logic [63:0] exp, input string tag);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 80'(lat), 80'(31));
        check({tag, " ct"}, 80'(out_data), 80'(exp));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " out_valid cleared"}, 80'(out_valid), 80'(0));
        check({tag, " back to idle"}, 80'(in_ready), 80'(1));
        check({tag, " busy cleared"}, 80'(busy), 80'(0));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        abort     = 1'b0;
        step();
        step();
        check("reset in_ready", 80'(in_ready), 80'(1));
        check("reset out_valid", 80'(out_valid), 80'(0));
        check("reset out_data", 80'(out_data), 80'(0));
        check("reset busy", 80'(busy), 80'(0));
        rst = 1'b0;
        step();

        // Published PRESENT-80 vectors.
        start_block(P0, K0, "v00");
        finish_block(64'h5579_C138_7B22_8445, "v00");
        release_out("v00");

        start_block(P0, KF, "v0f");
        finish_block(64'hE72C_46C0_F594_5049, "v0f");
        release_out("v0f");

        start_block(PF, K0, "vf0");
        finish_block(64'hA112_FFC7_2F68_417B, "vf0");
        release_out("vf0");

        start_block(PF, KF, "vff");
        finish_block(64'h3333_DCD3_2132_10D2, "vff");

        // Backpressure: ciphertext held, no new block taken.
        for (int c = 0; c < 10; c++) begin
            in_valid = ~in_valid;
            in_data  = {$urandom, $urandom};
            in_key   = 80'({$urandom, $urandom, $urandom});
            step();
            check("bp out_data", 80'(out_data), 80'(64'h3333_DCD3_2132_10D2));
            check("bp out_valid", 80'(out_valid), 80'(1));
            check("bp in_ready", 80'(in_ready), 80'(0));
        end
        in_valid = 1'b0;
        release_out("bp");
        check("idle keeps ct", 80'(out_data), 80'(64'h3333_DCD3_2132_10D2));

        start_block(PF, K0, "post bp");
        finish_block(64'hA112_FFC7_2F68_417B, "post bp");
        release_out("post bp");

        // Reset at round 15.
        start_block(P0, KF, "rst run");
        repeat (14) step();
        check("rst pre busy", 80'(busy), 80'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst out_valid", 80'(out_valid), 80'(0));
        check("rst busy", 80'(busy), 80'(0));
        check("rst in_ready", 80'(in_ready), 80'(1));
        check("rst out_data", 80'(out_data), 80'(0));

        start_block(P0, K0, "post rst");
        finish_block(64'h5579_C138_7B22_8445, "post rst");
        release_out("post rst");

`ifdef PRESENT80_ABORT_EN
        // Abort at round 15: previous ciphertext must survive.
        start_block(PF, KF, "abort run");
        repeat (14) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort out_valid", 80'(out_valid), 80'(0));
        check("abort busy", 80'(busy), 80'(0));
        check("abort in_ready", 80'(in_ready), 80'(1));
        check("abort out_data", 80'(out_data), 80'(64'h5579_C138_7B22_8445));

        start_block(P0, KF, "post abort");
        finish_block(64'hE72C_46C0_F594_5049, "post abort");
        release_out("post abort");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
